alu_addsub_seq: RTL

Parametrised multi-cycle adder/subtractor for the ALU. It computes `a + b + cin` or `a - b` on WIDTH-bit operands, one CHUNK-bit slice per clock, least-significant slice first. Operands enter and results leave through valid/ready handshakes. It produces unsigned carry/borrow, signed overflow and zero flags. The block replaces fixed-width combinational adders where WIDTH is large and area or timing matters more than latency.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_addsub_seq_if.sv | 25 ++
 rtl/alu_add_chunk.sv | 28 ++
 rtl/alu_full_adder.sv | 11 +
 rtl/alu_addsub_seq.sv | 115 +++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding and counter sizing helper.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } addsub_state_t;

    // A single-chunk datapath still needs a 1-bit counter to stay legal.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_addsub_seq_if.sv
// Operand/result handshake bundle for the sequential adder/subtractor.
interface alu_addsub_seq_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, out, carry, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, out, carry, overflow, zero
    );
endinterface

// File: rtl/alu_add_chunk.sv
// CHUNK-bit ripple adder; also exposes the carry into its top bit for overflow.
module alu_add_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        alu_full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout     = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];
endmodule

// File: rtl/alu_full_adder.sv
// One-bit full-adder cell.
module alu_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/alu_addsub_seq.sv
// Multi-cycle WIDTH-bit add/subtract, one CHUNK-bit slice per clock, LSB slice first.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | one chunk summed per cycle, result shifted in from the top
// DONE  | out_valid high, result and flags held until out_ready
module alu_addsub_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_addsub_seq_if.slave       bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    addsub_state_t    state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             cy;
    logic [CHUNK-1:0] sum;
    logic             c_out;
    logic             c_msb;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             carry_r;
    logic             ovf_r;
    logic             zero_r;

    alu_add_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a        (a_sr[CHUNK-1:0]),
        .b        (b_sr[CHUNK-1:0]),
        .cin      (cy),
        .sum      (sum),
        .cout     (c_out),
        .c_msb_in (c_msb)
    );

    if (NCHUNK == 1) begin : g_res_single
        assign res_next = sum;
    end else begin : g_res_shift
        assign res_next = {sum, res[WIDTH-1:CHUNK]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_sr        <= '0;
            b_sr        <= '0;
            res         <= '0;
            cnt         <= '0;
            cy          <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            carry_r     <= 1'b0;
            ovf_r       <= 1'b0;
            zero_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        a_sr       <= bus.a;
                        // Subtract is a + ~b + 1; cin is deliberately ignored here.
                        b_sr       <= bus.sub ? ~bus.b : bus.b;
                        cy         <= bus.sub | bus.cin;
                        cnt        <= '0;
                        in_ready_r <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> CHUNK;
                    b_sr <= b_sr >> CHUNK;
                    cy   <= c_out;
                    res  <= res_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        carry_r     <= c_out;
                        ovf_r       <= c_msb ^ c_out;
                        zero_r      <= ~|res_next;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    // in_ready rises only on the next edge, so no same-cycle accept.
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out       = res;
    assign bus.carry     = carry_r;
    assign bus.overflow  = ovf_r;
    assign bus.zero      = zero_r;
endmodule
